seq_checker: RTL and testbench

- Receive-side companion to the 3-bit odd-step sequence generator. Watches a stream of 3-bit codes and checks that they follow the cycle 000 -> 001 -> 011 -> 101 -> 111 -> 010 -> 000.
- Acquires lock, flywheels through isolated errors, and reports errors, illegal codes, position and cycle completion.
- Sits at the consumer end of the generator output, for example a link self-test or a counter health monitor.

---
 rtl/seq_checker_if.sv | 40 ++++
 rtl/seq_checker.sv | 170 +++++++++++++++++
 tb/tb_seq_checker.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/seq_checker_if.sv
// seq_checker_if
//   Bundles the code stream into seq_checker and its registered status
//   outputs.
//   master : the code source and status observer. It drives in_valid and
//            in_code and reads back the status.
//   slave  : the checker. It reads in_valid and in_code and drives the
//            status outputs.
//   Signals:
//     in_valid   in_code is sampled on this cycle
//     in_code    received 3-bit code
//     expected   code predicted for the next valid sample
//     index      position of expected in the cycle (0..5)
//     locked     high while the checker is locked
//     err        one-cycle pulse on a mismatch while locked
//     illegal    one-cycle pulse for code 100 or 110
//     wrap       one-cycle pulse on a matched 010 while locked
//     err_count  saturating count of err pulses
interface seq_checker_if #(
    parameter int ERR_W = 8
);
    logic             in_valid;
    logic [2:0]       in_code;
    logic [2:0]       expected;
    logic [2:0]       index;
    logic             locked;
    logic             err;
    logic             illegal;
    logic             wrap;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_valid, in_code,
        input  expected, index, locked, err, illegal, wrap, err_count
    );

    modport slave (
        input  in_valid, in_code,
        output expected, index, locked, err, illegal, wrap, err_count
    );
endinterface

// File: rtl/seq_checker.sv
// seq_checker
//   Receive-side checker for the 3-bit odd-step sequence
//   000 -> 001 -> 011 -> 101 -> 111 -> 010 -> 000.
//   It acquires lock after LOCK_N consecutive in-sequence codes. While locked
//   it flywheels through isolated errors. It drops lock after LOSE_N
//   consecutive mismatches. It reports errors, illegal codes, the predicted
//   position and cycle completion.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     bus    seq_checker_if.slave (in_valid/in_code in, status out)
//   Every status output except index is registered, with one cycle of
//   latency. index is decoded from the registered expected code.
module seq_checker #(
    parameter int LOCK_N = 3,
    parameter int LOSE_N = 2,
    parameter int ERR_W  = 8
) (
    input  logic          clk,
    input  logic          reset,
    seq_checker_if.slave  bus
);
    localparam logic [2:0] LOCK_C = 3'(LOCK_N);
    localparam logic [2:0] LOSE_C = 3'(LOSE_N);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic is_legal(input logic [2:0] c);
        return (c != 3'b100) && (c != 3'b110);
    endfunction

    function automatic logic [2:0] succ(input logic [2:0] c);
        case (c)
            3'b000:  return 3'b001;
            3'b001:  return 3'b011;
            3'b011:  return 3'b101;
            3'b101:  return 3'b111;
            3'b111:  return 3'b010;
            3'b010:  return 3'b000;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] code_to_index(input logic [2:0] c);
        case (c)
            3'b000:  return 3'd0;
            3'b001:  return 3'd1;
            3'b011:  return 3'd2;
            3'b101:  return 3'd3;
            3'b111:  return 3'd4;
            3'b010:  return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       expected_q, expected_d;
    logic [2:0]       match_cnt_q, match_cnt_d;
    logic [2:0]       miss_cnt_q, miss_cnt_d;
    logic             err_q, err_d;
    logic             illegal_q, illegal_d;
    logic             wrap_q, wrap_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_count_d = err_count_q;
        err_d       = 1'b0;
        illegal_d   = 1'b0;
        wrap_d      = 1'b0;

        if (bus.in_valid) begin
            illegal_d = !is_legal(bus.in_code);
            case (state_q)
                HUNT: begin
                    if (is_legal(bus.in_code)) begin
                        expected_d  = succ(bus.in_code);
                        match_cnt_d = 3'd1;
                        if (LOCK_C == 3'd1) begin
                            state_d    = LOCKED;
                            miss_cnt_d = 3'd0;
                        end else begin
                            state_d = SYNC;
                        end
                    end
                end
                SYNC: begin
                    if (!is_legal(bus.in_code)) begin
                        state_d     = HUNT;
                        match_cnt_d = 3'd0;
                    end else if (bus.in_code == expected_q) begin
                        match_cnt_d = match_cnt_q + 3'd1;
                        expected_d  = succ(expected_q);
                        if (match_cnt_q + 3'd1 == LOCK_C) begin
                            state_d    = LOCKED;
                            miss_cnt_d = 3'd0;
                        end
                    end else begin
                        // A wrong but legal code restarts acquisition from it.
                        expected_d  = succ(bus.in_code);
                        match_cnt_d = 3'd1;
                    end
                end
                LOCKED: begin
                    // The prediction advances whatever arrives, so one bad
                    // sample does not knock the checker out of phase.
                    expected_d = succ(expected_q);
                    if (bus.in_code == expected_q) begin
                        miss_cnt_d = 3'd0;
                        wrap_d     = (bus.in_code == 3'b010);
                    end else begin
                        err_d       = 1'b1;
                        err_count_d = sat_inc(err_count_q);
                        miss_cnt_d  = miss_cnt_q + 3'd1;
                        if (miss_cnt_q + 3'd1 == LOSE_C) begin
                            state_d     = HUNT;
                            match_cnt_d = 3'd0;
                        end
                    end
                end
                default: begin
                    state_d     = HUNT;
                    match_cnt_d = 3'd0;
                    miss_cnt_d  = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT;
            expected_q  <= 3'b000;
            match_cnt_q <= 3'd0;
            miss_cnt_q  <= 3'd0;
            err_q       <= 1'b0;
            illegal_q   <= 1'b0;
            wrap_q      <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_q       <= err_d;
            illegal_q   <= illegal_d;
            wrap_q      <= wrap_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.expected  = expected_q;
    assign bus.index     = code_to_index(expected_q);
    assign bus.locked    = (state_q == LOCKED);
    assign bus.err       = err_q;
    assign bus.illegal   = illegal_q;
    assign bus.wrap      = wrap_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_seq_checker.sv
module tb_seq_checker;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    // dut_a: default parameters. dut_b: LOSE_N=7 and a 2-bit error counter.
    seq_checker_if #(.ERR_W(8)) if_a ();
    seq_checker_if #(.ERR_W(2)) if_b ();

    seq_checker #(.LOCK_N(3), .LOSE_N(2), .ERR_W(8)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (if_a.slave)
    );

    seq_checker #(.LOCK_N(3), .LOSE_N(7), .ERR_W(2)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (if_b.slave)
    );

    always #5 clk = ~clk;

    // Layout {expected, index, locked, err, illegal, wrap, err_count[7:0]}.
    logic [17:0] qa[$];
    logic [17:0] qb[$];
    string       na[$];
    string       nb[$];
    int          checks = 0;
    int          errors = 0;

    // Sets one cycle of stimulus for the selected DUT and queues the
    // hand-computed state expected after the next rising edge.
    task automatic step(input bit which, input logic r, input logic v,
                        input logic [2:0] c, input logic [2:0] ex,
                        input logic [2:0] ix, input logic lk, input logic er,
                        input logic il, input logic wr, input logic [7:0] cnt,
                        input string nm);
        @(negedge clk);
        if (which == 1'b0) begin
            rst_a = r; if_a.in_valid = v; if_a.in_code = c;
            qa.push_back({ex, ix, lk, er, il, wr, cnt});
            na.push_back(nm);
        end else begin
            rst_b = r; if_b.in_valid = v; if_b.in_code = c;
            qb.push_back({ex, ix, lk, er, il, wr, cnt});
            nb.push_back(nm);
        end
    endtask

    // Monitor A
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (qa.size() > 0) begin
                logic [17:0] want;
                logic [17:0] got;
                string       nm;
                want = qa.pop_front();
                nm   = na.pop_front();
                got  = {if_a.expected, if_a.index, if_a.locked, if_a.err,
                        if_a.illegal, if_a.wrap, if_a.err_count};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL %s: got exp=%b idx=%0d lk=%b err=%b ill=%b wrap=%b cnt=%0d, want exp=%b idx=%0d lk=%b err=%b ill=%b wrap=%b cnt=%0d",
                             nm, got[17:15], got[14:12], got[11], got[10], got[9], got[8], got[7:0],
                             want[17:15], want[14:12], want[11], want[10], want[9], want[8], want[7:0]);
                end
            end
        end
    end

    // Monitor B
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (qb.size() > 0) begin
                logic [17:0] want;
                logic [17:0] got;
                string       nm;
                want = qb.pop_front();
                nm   = nb.pop_front();
                got  = {if_b.expected, if_b.index, if_b.locked, if_b.err,
                        if_b.illegal, if_b.wrap, 6'd0, if_b.err_count};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL %s: got exp=%b idx=%0d lk=%b err=%b ill=%b wrap=%b cnt=%0d, want exp=%b idx=%0d lk=%b err=%b ill=%b wrap=%b cnt=%0d",
                             nm, got[17:15], got[14:12], got[11], got[10], got[9], got[8], got[7:0],
                             want[17:15], want[14:12], want[11], want[10], want[9], want[8], want[7:0]);
                end
            end
        end
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        if_a.in_valid = 1'b0; if_a.in_code = 3'b000;
        if_b.in_valid = 1'b0; if_b.in_code = 3'b000;

        // ---- DUT A: LOCK_N=3, LOSE_N=2 ----
        //        w  r  v  code    exp     idx   lk er il wr cnt
        step(0, 1, 1, 3'b011, 3'b000, 3'd0, 0, 0, 0, 0, 8'd0, "reset_wins");
        step(0, 0, 1, 3'b000, 3'b001, 3'd1, 0, 0, 0, 0, 8'd0, "hunt_seed");
        step(0, 0, 1, 3'b001, 3'b011, 3'd2, 0, 0, 0, 0, 8'd0, "sync_match");
        step(0, 0, 1, 3'b011, 3'b101, 3'd3, 1, 0, 0, 0, 8'd0, "lock_acquire");
        step(0, 0, 1, 3'b101, 3'b111, 3'd4, 1, 0, 0, 0, 8'd0, "cycle_101");
        step(0, 0, 1, 3'b111, 3'b010, 3'd5, 1, 0, 0, 0, 8'd0, "cycle_111");
        step(0, 0, 1, 3'b010, 3'b000, 3'd0, 1, 0, 0, 1, 8'd0, "wrap_pulse");
        step(0, 0, 1, 3'b000, 3'b001, 3'd1, 1, 0, 0, 0, 8'd0, "cycle_000");
        step(0, 0, 0, 3'b111, 3'b001, 3'd1, 1, 0, 0, 0, 8'd0, "gap_locked");
        step(0, 0, 1, 3'b001, 3'b011, 3'd2, 1, 0, 0, 0, 8'd0, "adv_001");
        step(0, 0, 1, 3'b011, 3'b101, 3'd3, 1, 0, 0, 0, 8'd0, "adv_011");
        step(0, 0, 1, 3'b101, 3'b111, 3'd4, 1, 0, 0, 0, 8'd0, "adv_101");
        // Flywheel through an illegal code, then recover.
        step(0, 0, 1, 3'b110, 3'b010, 3'd5, 1, 1, 1, 0, 8'd1, "flywheel_illegal");
        step(0, 0, 1, 3'b010, 3'b000, 3'd0, 1, 0, 0, 1, 8'd1, "flywheel_recover");
        // Two consecutive wrong legal codes drop lock.
        step(0, 0, 1, 3'b011, 3'b001, 3'd1, 1, 1, 0, 0, 8'd2, "miss_one");
        step(0, 0, 1, 3'b111, 3'b011, 3'd2, 0, 1, 0, 0, 8'd3, "lose_lock");
        step(0, 0, 1, 3'b101, 3'b111, 3'd4, 0, 0, 0, 0, 8'd3, "rehunt_seed");
        step(0, 0, 1, 3'b111, 3'b010, 3'd5, 0, 0, 0, 0, 8'd3, "rehunt_sync");
        step(0, 0, 1, 3'b010, 3'b000, 3'd0, 1, 0, 0, 0, 8'd3, "relock_no_wrap");
        // SYNC re-seed with gaps between samples.
        step(0, 1, 0, 3'b000, 3'b000, 3'd0, 0, 0, 0, 0, 8'd0, "reset_clears_cnt");
        step(0, 0, 1, 3'b000, 3'b001, 3'd1, 0, 0, 0, 0, 8'd0, "rs_seed");
        step(0, 0, 0, 3'b010, 3'b001, 3'd1, 0, 0, 0, 0, 8'd0, "rs_gap1");
        step(0, 0, 1, 3'b001, 3'b011, 3'd2, 0, 0, 0, 0, 8'd0, "rs_match");
        step(0, 0, 0, 3'b100, 3'b011, 3'd2, 0, 0, 0, 0, 8'd0, "rs_gap2");
        step(0, 0, 1, 3'b111, 3'b010, 3'd5, 0, 0, 0, 0, 8'd0, "sync_reseed");
        step(0, 0, 0, 3'b110, 3'b010, 3'd5, 0, 0, 0, 0, 8'd0, "rs_gap3");
        step(0, 0, 1, 3'b010, 3'b000, 3'd0, 0, 0, 0, 0, 8'd0, "reseed_cnt2");
        step(0, 0, 1, 3'b000, 3'b001, 3'd1, 1, 0, 0, 0, 8'd0, "reseed_lock");
        // Illegal codes in HUNT and SYNC.
        step(0, 1, 1, 3'b000, 3'b000, 3'd0, 0, 0, 0, 0, 8'd0, "reset_again");
        step(0, 0, 1, 3'b100, 3'b000, 3'd0, 0, 0, 1, 0, 8'd0, "hunt_illegal");
        step(0, 0, 1, 3'b000, 3'b001, 3'd1, 0, 0, 0, 0, 8'd0, "hunt_after_ill");
        step(0, 0, 1, 3'b110, 3'b001, 3'd1, 0, 0, 1, 0, 8'd0, "sync_illegal");
        step(0, 0, 1, 3'b011, 3'b101, 3'd3, 0, 0, 0, 0, 8'd0, "back_in_hunt");
        step(0, 0, 0, 3'b000, 3'b101, 3'd3, 0, 0, 0, 0, 8'd0, "idle_a");

        // ---- DUT B: LOSE_N=7, ERR_W=2 ----
        step(1, 1, 0, 3'b000, 3'b000, 3'd0, 0, 0, 0, 0, 8'd0, "b_reset");
        step(1, 0, 1, 3'b000, 3'b001, 3'd1, 0, 0, 0, 0, 8'd0, "b_seed");
        step(1, 0, 1, 3'b001, 3'b011, 3'd2, 0, 0, 0, 0, 8'd0, "b_sync");
        step(1, 0, 1, 3'b011, 3'b101, 3'd3, 1, 0, 0, 0, 8'd0, "b_lock");
        step(1, 0, 1, 3'b110, 3'b111, 3'd4, 1, 1, 1, 0, 8'd1, "b_err1");
        step(1, 0, 1, 3'b110, 3'b010, 3'd5, 1, 1, 1, 0, 8'd2, "b_err2");
        step(1, 0, 1, 3'b110, 3'b000, 3'd0, 1, 1, 1, 0, 8'd3, "b_err3");
        step(1, 0, 1, 3'b110, 3'b001, 3'd1, 1, 1, 1, 0, 8'd3, "b_sat4");
        step(1, 0, 1, 3'b110, 3'b011, 3'd2, 1, 1, 1, 0, 8'd3, "b_sat5");
        step(1, 1, 1, 3'b011, 3'b000, 3'd0, 0, 0, 0, 0, 8'd0, "b_reset_midlock");
        step(1, 0, 0, 3'b000, 3'b000, 3'd0, 0, 0, 0, 0, 8'd0, "b_idle");

        // Bounded drain of both scoreboards.
        for (int i = 0; i < 10; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            @(posedge clk);
            #3;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: pending a=%0d b=%0d, want 0", qa.size(), qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
